// File: rtl/seg_scan_driver_if.sv
// Display-side bundle of seg_scan_driver: value/enable inputs in, scan outputs
// (nibble, anodes, decimal point) plus the scan FSM phase for observation.
interface seg_scan_driver_if;
    logic [31:0] data;
    logic [7:0]  digit_en;
    logic [7:0]  dp_in;
    logic        lz_en;
    logic [3:0]  x;
    logic [7:0]  an;
    logic        dp;
    logic        phase_dbg;   // 1 = SHOW, 0 = GAP (anodes forced off)

    modport master (
        output data, digit_en, dp_in, lz_en,
        input  x, an, dp, phase_dbg
    );

    modport slave (
        input  data, digit_en, dp_in, lz_en,
        output x, an, dp, phase_dbg
    );
endinterface

// File: rtl/seg_scan_driver.sv
// Time-multiplexed 8-digit common-anode scan driver with per-frame snapshot,
// blanking, leading-zero suppression and an anode-off guard at slot start.
module seg_scan_driver #(
    parameter int CLK_DIV = 100000,
    parameter int GAP_CYC = 1000
) (
    input logic               clk,
    input logic               rst,
    seg_scan_driver_if.slave  bus
);

    localparam int              CW      = $clog2(CLK_DIV);
    localparam logic [CW-1:0]   LAST_O  = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0]   GAP_O   = CW'(GAP_CYC);
    localparam bit              HAS_GAP = (GAP_CYC != 0);

    typedef enum logic {
        ST_GAP  = 1'b0,
        ST_SHOW = 1'b1
    } state_t;

    localparam state_t RST_STATE = HAS_GAP ? ST_GAP : ST_SHOW;

    // Scan position of the edge about to happen: offset within slot and slot index.
    logic [CW-1:0] cnt;
    logic [2:0]    idx;

    logic [31:0]   snap_data;
    logic [7:0]    snap_en;
    logic [7:0]    snap_dp;
    logic          snap_lz;

    state_t        state;
    state_t        nxt_state;

    logic [3:0]    x_q;
    logic [7:0]    an_q;
    logic          dp_q;

    logic          frame_start;
    logic [31:0]   cur_data;
    logic [7:0]    cur_en;
    logic [7:0]    cur_dp;
    logic          cur_lz;
    logic [2:0]    top_idx;
    logic [7:0]    vis;

    function automatic logic [2:0] top_nibble(input logic [31:0] v);
        logic [2:0] h;
        h = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (v[i*4 +: 4] != 4'h0) h = 3'(i);
        end
        return h;
    endfunction

    // The frame-start position already displays the values being captured on that edge.
    assign frame_start = (cnt == '0) && (idx == 3'd0);
    assign cur_data    = frame_start ? bus.data     : snap_data;
    assign cur_en      = frame_start ? bus.digit_en : snap_en;
    assign cur_dp      = frame_start ? bus.dp_in    : snap_dp;
    assign cur_lz      = frame_start ? bus.lz_en    : snap_lz;
    assign top_idx     = top_nibble(cur_data);

    always_comb begin
        vis = 8'h00;
        for (int i = 0; i < 8; i++) begin
            vis[i] = cur_en[i] && (!cur_lz || (3'(i) <= top_idx));
        end
    end

    // Phase of the position being produced on the coming edge.
    always_comb begin
        nxt_state = state;
        case (state)
            ST_GAP:  nxt_state = (cnt == GAP_O) ? ST_SHOW : ST_GAP;
            ST_SHOW: nxt_state = (HAS_GAP && (cnt == '0)) ? ST_GAP : ST_SHOW;
            default: nxt_state = RST_STATE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt       <= '0;
            idx       <= 3'd0;
            snap_data <= 32'h0;
            snap_en   <= 8'h00;
            snap_dp   <= 8'h00;
            snap_lz   <= 1'b0;
            state     <= RST_STATE;
            x_q       <= 4'h0;
            an_q      <= 8'hFF;
            dp_q      <= 1'b1;
        end else begin
            if (frame_start) begin
                snap_data <= bus.data;
                snap_en   <= bus.digit_en;
                snap_dp   <= bus.dp_in;
                snap_lz   <= bus.lz_en;
            end

            if (cnt == LAST_O) begin
                cnt <= '0;
                idx <= idx + 3'd1;
            end else begin
                cnt <= cnt + CW'(1);
            end

            state <= nxt_state;
            x_q   <= cur_data[{idx, 2'b00} +: 4];
            if ((nxt_state == ST_SHOW) && vis[idx]) begin
                an_q <= ~(8'h01 << idx);
                dp_q <= ~cur_dp[idx];
            end else begin
                an_q <= 8'hFF;
                dp_q <= 1'b1;
            end
        end
    end

    assign bus.x         = x_q;
    assign bus.an        = an_q;
    assign bus.dp        = dp_q;
    assign bus.phase_dbg = (state == ST_SHOW);

endmodule

// File: tb/tb_seg_scan_driver.sv
// Directed bench for seg_scan_driver (CLK_DIV=4): one instance with a 1-cycle
// guard, one with none; hand-computed per-position expectations via scoreboard queues.
module tb_seg_scan_driver;

    logic clk;
    logic rst_a;
    logic rst_b;

    seg_scan_driver_if ifa();
    seg_scan_driver_if ifb();

    seg_scan_driver #(.CLK_DIV(4), .GAP_CYC(1)) dut_a (
        .clk (clk),
        .rst (rst_a),
        .bus (ifa)
    );

    seg_scan_driver #(.CLK_DIV(4), .GAP_CYC(0)) dut_b (
        .clk (clk),
        .rst (rst_b),
        .bus (ifb)
    );

    // Entry layout: {check_an, check_x, check_dp, an[7:0], x[3:0], dp}
    logic [15:0] exp_a_q[$];
    logic [15:0] exp_b_q[$];

    int n_checks;
    int n_fail;

    logic [7:0] an_on [8];
    logic [3:0] xs    [8];

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL timeout: run did not finish, checks=%0d", n_checks);
        $fatal(1, "timeout");
    end

    function automatic logic [15:0] ent(input logic [7:0] an, input logic [3:0] x, input logic dp);
        return {3'b111, an, x, dp};
    endfunction

    // driver tasks: called between edges; push expectation for the next edge, then pass it
    task automatic push_a(input logic [15:0] e);
        exp_a_q.push_back(e);
        @(negedge clk);
    endtask

    task automatic push_b(input logic [15:0] e);
        exp_b_q.push_back(e);
        @(negedge clk);
    endtask

    task automatic slot_a(input logic [7:0] an_show, input logic [3:0] x, input logic dp_show);
        push_a(ent(8'hFF, x, 1'b1));
        repeat (3) push_a(ent(an_show, x, dp_show));
    endtask

    task automatic slot_b(input logic [7:0] an_show, input logic [3:0] x);
        repeat (4) push_b(ent(an_show, x, 1'b1));
    endtask

    // scoreboard
    task automatic check_entry(input string who, input logic [15:0] e,
                               input logic [7:0] an, input logic [3:0] x, input logic dp);
        if (e[15]) begin
            n_checks++;
            if (an !== e[12:5]) begin
                n_fail++;
                $display("FAIL %s an @%0t: got %h want %h", who, $time, an, e[12:5]);
            end
        end
        if (e[14]) begin
            n_checks++;
            if (x !== e[4:1]) begin
                n_fail++;
                $display("FAIL %s x @%0t: got %h want %h", who, $time, x, e[4:1]);
            end
        end
        if (e[13]) begin
            n_checks++;
            if (dp !== e[0]) begin
                n_fail++;
                $display("FAIL %s dp @%0t: got %b want %b", who, $time, dp, e[0]);
            end
        end
    endtask

    initial begin
        logic [15:0] e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_a_q.size() > 0) begin
                e = exp_a_q.pop_front();
                check_entry("dut_a", e, ifa.an, ifa.x, ifa.dp);
            end
        end
    end

    initial begin
        logic [15:0] e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_b_q.size() > 0) begin
                e = exp_b_q.pop_front();
                check_entry("dut_b", e, ifb.an, ifb.x, ifb.dp);
            end
        end
    end

    initial begin
        logic [15:0] rst_e;
        n_checks = 0;
        n_fail   = 0;
        an_on = '{8'hFE, 8'hFD, 8'hFB, 8'hF7, 8'hEF, 8'hDF, 8'hBF, 8'h7F};
        xs    = '{4'hD, 4'hC, 4'hB, 4'hA, 4'h4, 4'h3, 4'h2, 4'h1};
        rst_e = ent(8'hFF, 4'h0, 1'b1);

        rst_a = 1'b1;
        rst_b = 1'b1;
        ifa.data = 32'h1234ABCD; ifa.digit_en = 8'hFF; ifa.dp_in = 8'h00; ifa.lz_en = 1'b0;
        ifb.data = 32'h1234ABCD; ifb.digit_en = 8'hFF; ifb.dp_in = 8'h00; ifb.lz_en = 1'b0;
        @(negedge clk);

        // case 1: reset held 3 edges, run to p=13, one-cycle reset
        repeat (3) push_a(rst_e);
        rst_a = 1'b0;
        for (int i = 0; i < 3; i++) slot_a(an_on[i], xs[i], 1'b1);
        push_a(ent(8'hFF, 4'hA, 1'b1));
        push_a(ent(8'hF7, 4'hA, 1'b1));
        rst_a = 1'b1;
        push_a(rst_e);
        rst_a = 1'b0;

        // case 2: full scan order, then p=32..35 repeats slot 0
        for (int i = 0; i < 8; i++) slot_a(an_on[i], xs[i], 1'b1);
        slot_a(8'hFE, 4'hD, 1'b1);
        rst_a = 1'b1;
        push_a(rst_e);
        rst_a = 1'b0;

        // case 3: data -> 0 at p=10 is ignored until the next frame
        slot_a(an_on[0], xs[0], 1'b1);
        slot_a(an_on[1], xs[1], 1'b1);
        push_a(ent(8'hFF, 4'hB, 1'b1));
        push_a(ent(8'hFB, 4'hB, 1'b1));
        ifa.data = 32'h0;
        push_a(ent(8'hFB, 4'hB, 1'b1));
        push_a(ent(8'hFB, 4'hB, 1'b1));
        for (int i = 3; i < 8; i++) slot_a(an_on[i], xs[i], 1'b1);
        slot_a(8'hFE, 4'h0, 1'b1);
        slot_a(8'hFD, 4'h0, 1'b1);
        rst_a = 1'b1;
        push_a(rst_e);
        rst_a = 1'b0;

        // case 4: leading-zero suppression on 0xA5, then on 0
        ifa.data  = 32'h000000A5;
        ifa.lz_en = 1'b1;
        slot_a(8'hFE, 4'h5, 1'b1);
        slot_a(8'hFD, 4'hA, 1'b1);
        slot_a(8'hFF, 4'h0, 1'b1);
        slot_a(8'hFF, 4'h0, 1'b1);
        ifa.data = 32'h0;
        for (int i = 4; i < 8; i++) slot_a(8'hFF, 4'h0, 1'b1);
        slot_a(8'hFE, 4'h0, 1'b1);
        for (int i = 1; i < 8; i++) slot_a(8'hFF, 4'h0, 1'b1);
        rst_a = 1'b1;
        push_a(rst_e);
        rst_a = 1'b0;

        // case 5: blanking and decimal point
        ifa.data     = 32'h1234ABCD;
        ifa.lz_en    = 1'b0;
        ifa.digit_en = 8'b0000_0101;
        ifa.dp_in    = 8'h01;
        slot_a(8'hFE, 4'hD, 1'b0);
        slot_a(8'hFF, 4'hC, 1'b1);
        slot_a(8'hFB, 4'hB, 1'b1);
        for (int i = 3; i < 8; i++) slot_a(8'hFF, xs[i], 1'b1);

        // case 6: no guard interval, anode never fully off after reset
        push_b(rst_e);
        rst_b = 1'b0;
        for (int i = 0; i < 8; i++) slot_b(an_on[i], xs[i]);
        slot_b(8'hFE, 4'hD);

        repeat (4) @(negedge clk);
        n_checks++;
        if ((exp_a_q.size() + exp_b_q.size()) != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d pending entries want 0", exp_a_q.size() + exp_b_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
